// File: rtl/pac_grid_mover.sv
// Tile-grid sprite mover: one step per frame, turns latched from the keyboard and
// committed only at tile alignment after a wall-map query over a req/ack handshake.
module pac_grid_mover #(
    parameter int          W         = 10,
    parameter int          X_CENTER  = 320,
    parameter int          Y_CENTER  = 240,
    parameter int          X_MIN     = 0,
    parameter int          X_MAX     = 639,
    parameter int          Y_MIN     = 0,
    parameter int          Y_MAX     = 479,
    parameter int          STEP      = 1,
    parameter int          SIZE      = 4,
    parameter int          TILE_LOG2 = 3,
    parameter int          WRAP_X    = 0,
    parameter logic [15:0] KEY_UP    = 16'h001a,
    parameter logic [15:0] KEY_DOWN  = 16'h0016,
    parameter logic [15:0] KEY_LEFT  = 16'h0004,
    parameter logic [15:0] KEY_RIGHT = 16'h0007
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_clk,
    input  logic [15:0]  keycode,
    input  logic         wall_ack,
    input  logic         wall_blocked,
    output logic         wall_req,
    output logic [W-1:0] tile_x,
    output logic [W-1:0] tile_y,
    output logic [W-1:0] posX,
    output logic [W-1:0] posY,
    output logic [W-1:0] size,
    output logic [2:0]   dir,
    output logic         frame_overrun
);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        QUERY_TURN,
        QUERY_FWD,
        MOVE
    } state_t;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    // Edge arithmetic runs one bit wider so overflow past a bound is visible.
    localparam logic [W:0]   X_MIN_E = (W+1)'(X_MIN);
    localparam logic [W:0]   X_MAX_E = (W+1)'(X_MAX);
    localparam logic [W:0]   Y_MIN_E = (W+1)'(Y_MIN);
    localparam logic [W:0]   Y_MAX_E = (W+1)'(Y_MAX);
    localparam logic [W:0]   STEP_E  = (W+1)'(STEP);
    localparam logic [W:0]   SPAN_E  = (W+1)'(X_MAX - X_MIN + 1);
    localparam logic [W-1:0] X_MIN_W = W'(X_MIN);
    localparam logic [W-1:0] X_MAX_W = W'(X_MAX);
    localparam logic [W-1:0] Y_MIN_W = W'(Y_MIN);
    localparam logic [W-1:0] Y_MAX_W = W'(Y_MAX);
    localparam logic [W-1:0] STEP_W  = W'(STEP);
    localparam logic [W-1:0] ONE_W   = W'(1);

    state_t         state;
    logic [2:0]     pending;
    logic [2:0]     key_dir;
    logic [2:0]     query_dir;
    logic           frame_sync;
    logic           frame_prev;
    logic           frame_rise;
    logic           aligned;
    logic [W-1:0]   cur_tx;
    logic [W-1:0]   cur_ty;
    logic [W-1:0]   next_tx;
    logic [W-1:0]   next_ty;
    logic [W:0]     pos_x_e;
    logic [W:0]     pos_y_e;

    assign size       = W'(SIZE);
    assign frame_rise = frame_sync & ~frame_prev;
    assign aligned    = (posX[TILE_LOG2-1:0] == '0) && (posY[TILE_LOG2-1:0] == '0);
    assign cur_tx     = posX >> TILE_LOG2;
    assign cur_ty     = posY >> TILE_LOG2;
    assign pos_x_e    = {1'b0, posX};
    assign pos_y_e    = {1'b0, posY};
    assign query_dir  = (state == QUERY_TURN) ? pending : dir;

    always_comb begin
        key_dir = DIR_NONE;
        if (keycode == KEY_UP)
            key_dir = DIR_UP;
        else if (keycode == KEY_DOWN)
            key_dir = DIR_DOWN;
        else if (keycode == KEY_LEFT)
            key_dir = DIR_LEFT;
        else if (keycode == KEY_RIGHT)
            key_dir = DIR_RIGHT;
    end

    // Neighbouring tile in whichever direction the current query is about.
    always_comb begin
        next_tx = cur_tx;
        next_ty = cur_ty;
        case (query_dir)
            DIR_UP:    next_ty = cur_ty - ONE_W;
            DIR_DOWN:  next_ty = cur_ty + ONE_W;
            DIR_LEFT:  next_tx = cur_tx - ONE_W;
            DIR_RIGHT: next_tx = cur_tx + ONE_W;
            default:   ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= WAIT_FRAME;
            posX          <= W'(X_CENTER);
            posY          <= W'(Y_CENTER);
            dir           <= DIR_NONE;
            pending       <= DIR_NONE;
            wall_req      <= 1'b0;
            tile_x        <= '0;
            tile_y        <= '0;
            frame_overrun <= 1'b0;
            frame_sync    <= 1'b0;
            frame_prev    <= 1'b0;
        end else begin
            frame_sync <= frame_clk;
            frame_prev <= frame_sync;
            if (frame_rise && state != WAIT_FRAME)
                frame_overrun <= 1'b1;

            case (state)
                WAIT_FRAME: begin
                    if (frame_rise) begin
                        if (aligned && pending != DIR_NONE && pending != dir)
                            state <= QUERY_TURN;
                        else if (aligned && dir != DIR_NONE)
                            state <= QUERY_FWD;
                        else
                            state <= MOVE;
                    end
                end

                // Request is raised once, with the tile frozen until the ack arrives.
                QUERY_TURN: begin
                    if (!wall_req) begin
                        wall_req <= 1'b1;
                        tile_x   <= next_tx;
                        tile_y   <= next_ty;
                    end else if (wall_ack) begin
                        wall_req <= 1'b0;
                        if (!wall_blocked) begin
                            dir     <= pending;
                            pending <= DIR_NONE;
                            state   <= (pending != DIR_NONE) ? QUERY_FWD : MOVE;
                        end else begin
                            state   <= (dir != DIR_NONE) ? QUERY_FWD : MOVE;
                        end
                    end
                end

                QUERY_FWD: begin
                    if (!wall_req) begin
                        wall_req <= 1'b1;
                        tile_x   <= next_tx;
                        tile_y   <= next_ty;
                    end else if (wall_ack) begin
                        wall_req <= 1'b0;
                        if (wall_blocked)
                            dir <= DIR_NONE;
                        state <= MOVE;
                    end
                end

                // Y and non-wrapping X saturate at the bound and stop the sprite.
                MOVE: begin
                    case (dir)
                        DIR_UP: begin
                            if (pos_y_e < Y_MIN_E + STEP_E) begin
                                posY <= Y_MIN_W;
                                dir  <= DIR_NONE;
                            end else begin
                                posY <= posY - STEP_W;
                            end
                        end
                        DIR_DOWN: begin
                            if (pos_y_e + STEP_E > Y_MAX_E) begin
                                posY <= Y_MAX_W;
                                dir  <= DIR_NONE;
                            end else begin
                                posY <= posY + STEP_W;
                            end
                        end
                        DIR_LEFT: begin
                            if (pos_x_e < X_MIN_E + STEP_E) begin
                                if (WRAP_X != 0) begin
                                    posX <= W'(pos_x_e + SPAN_E - STEP_E);
                                end else begin
                                    posX <= X_MIN_W;
                                    dir  <= DIR_NONE;
                                end
                            end else begin
                                posX <= posX - STEP_W;
                            end
                        end
                        DIR_RIGHT: begin
                            if (pos_x_e + STEP_E > X_MAX_E) begin
                                if (WRAP_X != 0) begin
                                    posX <= W'(pos_x_e + STEP_E - SPAN_E);
                                end else begin
                                    posX <= X_MAX_W;
                                    dir  <= DIR_NONE;
                                end
                            end else begin
                                posX <= posX + STEP_W;
                            end
                        end
                        default: ;
                    endcase
                    state <= WAIT_FRAME;
                end

                default: state <= WAIT_FRAME;
            endcase

            // A key seen this cycle outranks the clear from a committed turn.
            if (key_dir != DIR_NONE)
                pending <= key_dir;
        end
    end

endmodule

// File: tb/tb_pac_grid_mover.sv
// Directed bench for pac_grid_mover: one centred clamping instance plus a
// wrapping/clamping pair placed near the right edge.
module tb_pac_grid_mover;

    localparam logic [15:0] K_UP    = 16'h001a;
    localparam logic [15:0] K_LEFT  = 16'h0004;
    localparam logic [15:0] K_RIGHT = 16'h0007;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [15:0] keycode;
    logic        wall_ack;
    logic        wall_blocked;
    logic        wall_req;
    logic [9:0]  tile_x, tile_y, posX, posY, size;
    logic [2:0]  dir;
    logic        frame_overrun;

    logic        frame_e;
    logic [15:0] key_e;
    logic        ack_e0, ack_e1;
    logic        req_e0, req_e1;
    logic [9:0]  tx_e0, ty_e0, tx_e1, ty_e1;
    logic [9:0]  px_e0, py_e0, px_e1, py_e1, sz_e0, sz_e1;
    logic [2:0]  dir_e0, dir_e1;
    logic        ovr_e0, ovr_e1;

    int assert_count = 0;
    int fail_count   = 0;
    int first_tx, first_ty;
    int nq;

    always #5 Clk = ~Clk;

    pac_grid_mover dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .wall_ack(wall_ack), .wall_blocked(wall_blocked), .wall_req(wall_req),
        .tile_x(tile_x), .tile_y(tile_y), .posX(posX), .posY(posY), .size(size),
        .dir(dir), .frame_overrun(frame_overrun)
    );

    pac_grid_mover #(.X_CENTER(632), .WRAP_X(0)) dut_clamp (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_e), .keycode(key_e),
        .wall_ack(ack_e0), .wall_blocked(1'b0), .wall_req(req_e0),
        .tile_x(tx_e0), .tile_y(ty_e0), .posX(px_e0), .posY(py_e0), .size(sz_e0),
        .dir(dir_e0), .frame_overrun(ovr_e0)
    );

    pac_grid_mover #(.X_CENTER(632), .WRAP_X(1)) dut_wrap (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_e), .keycode(key_e),
        .wall_ack(ack_e1), .wall_blocked(1'b0), .wall_req(req_e1),
        .tile_x(tx_e1), .tile_y(ty_e1), .posX(px_e1), .posY(py_e1), .size(sz_e1),
        .dir(dir_e1), .frame_overrun(ovr_e1)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        assert_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One frame on the main instance: acks each query two cycles after it is seen,
    // answering the first with b0 and later ones with b1; nq_out counts acks given.
    task automatic applyStimulus(input bit ack_on, input bit b0, input bit b1, output int nq_out);
        int wait_cnt = 0;
        nq_out = 0;
        @(negedge Clk);
        frame_clk = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (c == 3)
                frame_clk = 1'b0;
            if (wall_ack) begin
                wall_ack = 1'b0;
            end else if (ack_on && wall_req) begin
                wait_cnt++;
                if (wait_cnt == 2) begin
                    if (nq_out == 0) begin
                        first_tx = int'(tile_x);
                        first_ty = int'(tile_y);
                    end
                    wall_blocked = (nq_out == 0) ? b0 : b1;
                    wall_ack     = 1'b1;
                    nq_out++;
                    wait_cnt = 0;
                end
            end
        end
    endtask

    task automatic applyEdgeFrame();
        @(negedge Clk);
        frame_e = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (c == 3)
                frame_e = 1'b0;
            ack_e0 = req_e0 && !ack_e0;
            ack_e1 = req_e1 && !ack_e1;
        end
    endtask

    initial begin
        Reset = 1'b1;
        frame_clk = 1'b0;
        keycode = 16'h0000;
        wall_ack = 1'b0;
        wall_blocked = 1'b0;
        frame_e = 1'b0;
        key_e = 16'h0000;
        ack_e0 = 1'b0;
        ack_e1 = 1'b0;
        repeat (3) @(negedge Clk);

        checkOutput("reset_posX", int'(posX), 320);
        checkOutput("reset_posY", int'(posY), 240);
        checkOutput("reset_dir", int'(dir), 0);
        checkOutput("reset_req", int'(wall_req), 0);
        checkOutput("reset_tile_x", int'(tile_x), 0);
        checkOutput("reset_overrun", int'(frame_overrun), 0);
        checkOutput("size", int'(size), 4);
        Reset = 1'b0;
        @(negedge Clk);

        // Start moving right from the aligned centre: turn and forward queries.
        keycode = K_RIGHT;
        applyStimulus(1'b1, 1'b0, 1'b0, nq);
        checkOutput("f1_queries", nq, 2);
        checkOutput("f1_posX", int'(posX), 321);
        checkOutput("f1_dir", int'(dir), 4);

        for (int f = 2; f <= 5; f++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, nq);
            checkOutput($sformatf("f%0d_queries", f), nq, 0);
        end
        checkOutput("f5_posX", int'(posX), 325);

        // Up requested between tiles: nothing happens until x=328.
        keycode = K_UP;
        for (int f = 6; f <= 8; f++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, nq);
            checkOutput($sformatf("f%0d_queries", f), nq, 0);
        end
        checkOutput("f8_posX", int'(posX), 328);
        checkOutput("f8_dir", int'(dir), 4);

        applyStimulus(1'b1, 1'b0, 1'b0, nq);
        checkOutput("f9_queries", nq, 2);
        checkOutput("turn_tile_x", first_tx, 41);
        checkOutput("turn_tile_y", first_ty, 29);
        checkOutput("f9_dir", int'(dir), 1);
        checkOutput("f9_posY", int'(posY), 239);
        checkOutput("f9_posX", int'(posX), 328);

        // Queue a right turn while climbing to y=232.
        keycode = K_RIGHT;
        for (int f = 10; f <= 16; f++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, nq);
            checkOutput($sformatf("f%0d_queries", f), nq, 0);
        end
        checkOutput("f16_posY", int'(posY), 232);

        // Turn accepted, forward blocked: sprite stops at 328.
        keycode = 16'h0000;
        applyStimulus(1'b1, 1'b0, 1'b1, nq);
        checkOutput("f17_queries", nq, 2);
        checkOutput("f17_dir", int'(dir), 0);
        checkOutput("f17_posX", int'(posX), 328);
        applyStimulus(1'b1, 1'b0, 1'b0, nq);
        checkOutput("f18_queries", nq, 0);
        checkOutput("f18_posX", int'(posX), 328);
        checkOutput("f18_posY", int'(posY), 232);

        // Starve the turn query across two frame edges.
        keycode = K_LEFT;
        applyStimulus(1'b0, 1'b0, 1'b0, nq);
        checkOutput("stall_req", int'(wall_req), 1);
        checkOutput("stall_tile_x", int'(tile_x), 40);
        checkOutput("stall_tile_y", int'(tile_y), 29);
        checkOutput("stall_overrun_first", int'(frame_overrun), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, nq);
        checkOutput("stall_overrun", int'(frame_overrun), 1);
        checkOutput("stall_posX", int'(posX), 328);
        keycode = 16'h0000;
        applyStimulus(1'b1, 1'b0, 1'b0, nq);
        checkOutput("resume_queries", nq, 2);
        checkOutput("resume_posX", int'(posX), 327);
        checkOutput("resume_dir", int'(dir), 3);
        checkOutput("resume_overrun", int'(frame_overrun), 1);

        for (int f = 22; f <= 28; f++)
            applyStimulus(1'b1, 1'b0, 1'b0, nq);
        checkOutput("f28_posX", int'(posX), 320);

        // Park in a forward query, then reset asynchronously mid-query.
        applyStimulus(1'b0, 1'b0, 1'b0, nq);
        checkOutput("fwd_req", int'(wall_req), 1);
        checkOutput("fwd_tile_x", int'(tile_x), 39);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("rst_mid_req", int'(wall_req), 0);
        checkOutput("rst_mid_posX", int'(posX), 320);
        checkOutput("rst_mid_posY", int'(posY), 240);
        checkOutput("rst_mid_dir", int'(dir), 0);
        checkOutput("rst_mid_overrun", int'(frame_overrun), 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Right edge: wrap to 0 versus clamp-and-stop at 639.
        key_e = K_RIGHT;
        for (int f = 1; f <= 7; f++)
            applyEdgeFrame();
        checkOutput("edge_clamp_pre", int'(px_e0), 639);
        checkOutput("edge_wrap_pre", int'(px_e1), 639);
        checkOutput("edge_wrap_pre_dir", int'(dir_e1), 4);
        applyEdgeFrame();
        checkOutput("edge_wrap_posX", int'(px_e1), 0);
        checkOutput("edge_wrap_dir", int'(dir_e1), 4);
        checkOutput("edge_clamp_posX", int'(px_e0), 639);
        checkOutput("edge_clamp_dir", int'(dir_e0), 0);
        applyEdgeFrame();
        checkOutput("edge_wrap_next", int'(px_e1), 1);
        checkOutput("edge_clamp_held", int'(px_e0), 639);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/pac_grid_mover.md
Name: pac_grid_mover

Overview:
Parametrised successor to the single-sprite free-motion controller. Moves one sprite (Pac-Man or ghost) on a tile grid at one step per frame. Latches a requested turn from the keyboard and applies it only at tile alignment. Before each turn and each forward move at alignment, queries the maze wall map through a req/ack handshake. Sits between the keyboard decoder, the maze ROM arbiter and the sprite renderer.

Parameters:
W, 10, coordinate width in bits
X_CENTER, 320, reset X position
Y_CENTER, 240, reset Y position
X_MIN / X_MAX, 0 / 639, legal X range, inclusive
Y_MIN / Y_MAX, 0 / 479, legal Y range, inclusive
STEP, 1, pixels per frame; must divide 2**TILE_LOG2
SIZE, 4, sprite half-size reported on size output
TILE_LOG2, 3, tile edge = 2**TILE_LOG2 pixels
WRAP_X, 0, 1 = horizontal tunnel wrap; 0 = clamp and stop
KEY_UP / KEY_DOWN / KEY_LEFT / KEY_RIGHT, 16'h001a / 16'h0016 / 16'h0004 / 16'h0007, keycodes

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  frame strobe (vsync-derived); rising edge detected internally on Clk
keycode  in  16  current key
wall_ack  in  1  wall map response valid
wall_blocked  in  1  target tile is a wall; sampled only when wall_ack=1
wall_req  out  1  query pending
tile_x, tile_y  out  W  queried tile coordinates
posX, posY  out  W  sprite position
size  out  W  equals SIZE
dir  out  3  current direction: 0 none, 1 up, 2 down, 3 left, 4 right
frame_overrun  out  1  sticky flag

Behaviour:
- Reset (async, any state): posX=X_CENTER, posY=Y_CENTER, dir=0, pending=0, wall_req=0, tile_x=tile_y=0, frame_overrun=0, FSM=WAIT_FRAME, frame_clk edge detector cleared.
- Pending turn: every Clk, a keycode matching one of the four key parameters loads pending with that direction. Non-matching keycodes leave pending unchanged.
- aligned = both posX and posY have their low TILE_LOG2 bits equal to 0. Tile coordinate = pos >> TILE_LOG2.
- FSM states: WAIT_FRAME, QUERY_TURN, QUERY_FWD, MOVE.
  - WAIT_FRAME: on a frame_clk rising edge:
    - aligned and pending != 0 and pending != dir -> QUERY_TURN
    - else aligned and dir != 0 -> QUERY_FWD
    - else -> MOVE
  - QUERY_TURN: wall_req=1; tile_x/tile_y = tile plus a ±1 offset in the pending direction. Hold until wall_ack.
    - wall_blocked=0: dir<=pending, pending<=0.
    - Either outcome -> QUERY_FWD if dir (updated) != 0, else MOVE.
  - QUERY_FWD: wall_req=1; tile_x/tile_y = neighbouring tile in dir. On wall_ack: dir<=0 if blocked. -> MOVE.
  - MOVE: one cycle. Step pos by STEP in dir, using the dir value decided this frame, never a stale one. -> WAIT_FRAME.
- wall_req rises the cycle after entering a query state and falls the cycle after wall_ack. tile_x/tile_y are stable while wall_req=1. wall_ack outside a query state is ignored.
- Edge handling (modular arithmetic, width W+1 internally):
  - Left/right with WRAP_X=1: result beyond the range wraps by span = X_MAX-X_MIN+1.
  - WRAP_X=0, and all Y motion: result saturates at the bound and dir<=0.
- A frame_clk edge seen outside WAIT_FRAME is dropped and sets frame_overrun, which is cleared only by Reset.
- No wall_ack: the FSM waits indefinitely; position frozen.
- Latency: frame edge to pos update is 3 Clk cycles with no query; query cycles plus 1 otherwise.

Test Plan:
1. Reset mid-QUERY_FWD with wall_req=1 -> next Clk: wall_req=0, posX=320, posY=240, dir=0.
2. keycode=16'h0007, ack after 2 cycles, blocked=0, 8 frames -> dir=4, posX=328; a query is issued on frames 1 and 9 only.
3. Moving right, keycode=16'h001a at posX=325 -> no turn until posX=328; QUERY_TURN there with tile_y=29; on unblocked ack, dir=1 and posY=239 on the same frame.
4. Moving right at posX=336, QUERY_FWD returns blocked -> dir=0, posX stays 336 for later frames.
5. WRAP_X=1, posX=639, dir=4, forward unblocked -> posX=0. With WRAP_X=0 -> posX=639, dir=0.
6. Hold wall_ack low for 2 frame edges -> frame_overrun=1, position unchanged. Release ack -> movement resumes; flag stays 1.
